// File: rtl/hazard_unit.sv
// hazard_unit: forwarding selects and stall/flush control for the 5-stage ARM
// pipeline. A two-state FSM holds the pipeline while a multi-cycle multiply
// occupies Execute.
// Optional build macro: HAZARD_PERF_CNT_EN adds saturating StallCycles and
// FlushCycles counters.
module hazard_unit #(
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] RA1D,
    input  logic [3:0] RA2D,
    input  logic [3:0] RA1E,
    input  logic [3:0] RA2E,
    input  logic [3:0] WA3E,
    input  logic [3:0] WA3M,
    input  logic [3:0] WA3W,
    input  logic       RegWriteE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemtoRegE,
    input  logic       PCWrPendingF,
    input  logic       PCSrcW,
    input  logic       BranchTakenD,
    input  logic       MulOpE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic       MulBusyE,
    output logic       MulDoneE
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] StallCycles,
    output logic [31:0] FlushCycles
`endif
);

    typedef enum logic {IDLE = 1'b0, MUL_BUSY = 1'b1} state_t;

    // A single-cycle multiply never enters MUL_BUSY; the counter holds the
    // number of stall cycles still to come after the current one.
    localparam logic             MUL_MULTI = (MUL_CYCLES > 1);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'((MUL_CYCLES > 1) ? (MUL_CYCLES - 2) : 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mul_stall;
    logic             mul_done;
    logic             ldr_stall;

    // Register 15 is the PC and is never forwarded; M has priority over W.
    function automatic logic [1:0] fwd_sel(input logic [3:0] ra);
        logic [1:0] sel;
        sel = 2'b00;
        if (ra != 4'hF) begin
            if (RegWriteM && (ra == WA3M))      sel = 2'b10;
            else if (RegWriteW && (ra == WA3W)) sel = 2'b01;
        end
        return sel;
    endfunction

    // Multiply FSM state and countdown registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Multiply FSM next state, stall request and completion pulse.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mul_stall = 1'b0;
        mul_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (MulOpE && MUL_MULTI) begin
                    mul_stall = 1'b1;
                    state_d   = MUL_BUSY;
                    cnt_d     = CNT_LOAD;
                end
            end
            MUL_BUSY: begin
                if (cnt_q != '0) begin
                    mul_stall = 1'b1;
                    cnt_d     = cnt_q - CNT_W'(1);
                end else begin
                    mul_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Forwarding, load-use and stall/flush outputs; all forced low in reset.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        MulBusyE  = 1'b0;
        MulDoneE  = 1'b0;
        ldr_stall = MemtoRegE && RegWriteE && ((RA1D == WA3E) || (RA2D == WA3E));
        if (reset_n) begin
            ForwardAE = fwd_sel(RA1E);
            ForwardBE = fwd_sel(RA2E);
            MulBusyE  = (state_q == MUL_BUSY);
            MulDoneE  = mul_done;
            if (mul_stall) begin
                // Multiply holds everything; pending flushes wait for release.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                FlushM = 1'b1;
            end else begin
                StallD = ldr_stall;
                StallF = ldr_stall || PCWrPendingF;
                FlushD = PCWrPendingF || PCSrcW || BranchTakenD;
                FlushE = ldr_stall || BranchTakenD;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_cycles_q, flush_cycles_d;

    // Saturating event counters for stall and flush cycles.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_cycles_d = flush_cycles_q;
        if (StallF && (stall_cycles_q != 32'hFFFF_FFFF))
            stall_cycles_d = stall_cycles_q + 32'd1;
        if ((FlushD || FlushE || FlushM) && (flush_cycles_q != 32'hFFFF_FFFF))
            flush_cycles_d = flush_cycles_q + 32'd1;
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles_q <= '0;
            flush_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_cycles_q <= flush_cycles_d;
        end
    end

    assign StallCycles = stall_cycles_q;
    assign FlushCycles = flush_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed stimulus for hazard_unit (MUL_CYCLES=4 and =1
// instances) with a behavioural model checked every cycle plus literal checks.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] RA1D = '0, RA2D = '0, RA1E = '0, RA2E = '0;
    logic [3:0] WA3E = '0, WA3M = '0, WA3W = '0;
    logic       RegWriteE = 0, RegWriteM = 0, RegWriteW = 0, MemtoRegE = 0;
    logic       PCWrPendingF = 0, PCSrcW = 0, BranchTakenD = 0, MulOpE = 0;

    logic [1:0] ForwardAE, ForwardBE, ForwardAE_1, ForwardBE_1;
    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusyE, MulDoneE;
    logic       StallF_1, StallD_1, StallE_1, FlushD_1, FlushE_1, FlushM_1, MulBusyE_1, MulDoneE_1;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] StallCycles, FlushCycles, StallCycles_1, FlushCycles_1;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_unit #(.MUL_CYCLES(4), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE), .PCWrPendingF(PCWrPendingF),
        .PCSrcW(PCSrcW), .BranchTakenD(BranchTakenD), .MulOpE(MulOpE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
        .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .MulBusyE(MulBusyE), .MulDoneE(MulDoneE)
`ifdef HAZARD_PERF_CNT_EN
        , .StallCycles(StallCycles), .FlushCycles(FlushCycles)
`endif
    );

    hazard_unit #(.MUL_CYCLES(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE), .PCWrPendingF(PCWrPendingF),
        .PCSrcW(PCSrcW), .BranchTakenD(BranchTakenD), .MulOpE(MulOpE),
        .ForwardAE(ForwardAE_1), .ForwardBE(ForwardBE_1), .StallF(StallF_1), .StallD(StallD_1),
        .StallE(StallE_1), .FlushD(FlushD_1), .FlushE(FlushE_1), .FlushM(FlushM_1),
        .MulBusyE(MulBusyE_1), .MulDoneE(MulDoneE_1)
`ifdef HAZARD_PERF_CNT_EN
        , .StallCycles(StallCycles_1), .FlushCycles(FlushCycles_1)
`endif
    );

    typedef struct packed {
        logic [1:0] fa;
        logic [1:0] fb;
        logic sf, sd, se, fd, fe, fm, busy, done;
    } exp_t;

    // Model state: number of Execute cycles the current multiply still has
    // to spend after this one is counted (0 = no multiply in progress).
    int rem4 = 0;
    int rem1 = 0;
    logic [31:0] st4 = 0, fl4 = 0, st1 = 0, fl1 = 0;

    function automatic logic [1:0] fwd_model(input logic [3:0] ra);
        if (ra == 4'd15) return 2'b00;
        if (RegWriteM && ra == WA3M) return 2'b10;
        if (RegWriteW && ra == WA3W) return 2'b01;
        return 2'b00;
    endfunction

    // rem counts Execute cycles left including the current one.
    function automatic exp_t model(input int mc, input int rem);
        exp_t e;
        logic ldr, stall;
        e = '0;
        if (!reset_n) return e;
        e.fa   = fwd_model(RA1E);
        e.fb   = fwd_model(RA2E);
        ldr    = MemtoRegE && RegWriteE && (RA1D == WA3E || RA2D == WA3E);
        stall  = (rem == 0 && MulOpE && mc > 1) || (rem > 1);
        e.busy = (rem > 0);
        e.done = (rem == 1);
        if (stall) begin
            e.sf = 1; e.sd = 1; e.se = 1; e.fm = 1;
        end else begin
            e.sd = ldr;
            e.sf = ldr | PCWrPendingF;
            e.fd = PCWrPendingF | PCSrcW | BranchTakenD;
            e.fe = ldr | BranchTakenD;
        end
        return e;
    endfunction

    function automatic int next_rem(input int mc, input int rem);
        if (rem > 0) return rem - 1;
        if (MulOpE && mc > 1) return mc - 1;
        return 0;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic ev);
        return (ev && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

    // Advance the model on each clock edge.
    always @(posedge clk or negedge reset_n) begin
        exp_t e4, e1;
        if (!reset_n) begin
            rem4 <= 0; rem1 <= 0; st4 <= 0; fl4 <= 0; st1 <= 0; fl1 <= 0;
        end else begin
            e4 = model(4, rem4);
            e1 = model(1, rem1);
            st4 <= sat_inc(st4, e4.sf);
            fl4 <= sat_inc(fl4, e4.fd | e4.fe | e4.fm);
            st1 <= sat_inc(st1, e1.sf);
            fl1 <= sat_inc(fl1, e1.fd | e1.fe | e1.fm);
            rem4 <= next_rem(4, rem4);
            rem1 <= next_rem(1, rem1);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("cycle_dut4", 32'({ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE,
                               FlushM, MulBusyE, MulDoneE}), 32'(model(4, rem4)));
        chk("cycle_dut1", 32'({ForwardAE_1, ForwardBE_1, StallF_1, StallD_1, StallE_1, FlushD_1,
                               FlushE_1, FlushM_1, MulBusyE_1, MulDoneE_1}), 32'(model(1, rem1)));
`ifdef HAZARD_PERF_CNT_EN
        chk("cycle_stallcnt4", StallCycles, st4);
        chk("cycle_flushcnt4", FlushCycles, fl4);
        chk("cycle_stallcnt1", StallCycles_1, st1);
        chk("cycle_flushcnt1", FlushCycles_1, fl1);
`endif
    end

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk); #1;
    endtask

    task automatic clr();
        RA1D = 0; RA2D = 0; RA1E = 0; RA2E = 0; WA3E = 0; WA3M = 0; WA3W = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0;
        PCWrPendingF = 0; PCSrcW = 0; BranchTakenD = 0; MulOpE = 0;
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, 32'({ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM,
                       MulBusyE, MulDoneE}), 32'd0);
    endtask

    initial begin
        // Reset state, with inputs that would otherwise produce activity.
        RegWriteM = 1; WA3M = 3; RA1E = 3; MulOpE = 1; BranchTakenD = 1;
        mid();
        chk_all_zero("reset_outputs");
        nxt(); clr(); reset_n = 1;
        mid();
        chk_all_zero("after_reset_idle");
        $display("txn reset release");

        // Forward priority M over W, and W-only, and R15.
        nxt(); RegWriteM = 1; WA3M = 3; RegWriteW = 1; WA3W = 3; RA1E = 3; RA2E = 5;
        mid(); chk("fwd_prio_A", ForwardAE, 2'b10); chk("fwd_prio_B", ForwardBE, 2'b00);
        $display("txn forward M/W priority");
        nxt(); RegWriteM = 0; RA2E = 3;
        mid(); chk("fwd_w_A", ForwardAE, 2'b01); chk("fwd_w_B", ForwardBE, 2'b01);
        $display("txn forward W only");
        nxt(); RegWriteM = 1; WA3M = 15; WA3W = 15; RA1E = 15; RA2E = 15;
        mid(); chk("fwd_r15_A", ForwardAE, 2'b00); chk("fwd_r15_B", ForwardBE, 2'b00);
        $display("txn forward r15");

        // Load-use.
        nxt(); clr(); MemtoRegE = 1; RegWriteE = 1; WA3E = 2; RA2D = 2;
        mid();
        chk("ldr_stallF", StallF, 1); chk("ldr_stallD", StallD, 1);
        chk("ldr_flushE", FlushE, 1); chk("ldr_flushD", FlushD, 0);
        nxt(); clr();
        mid(); chk("ldr_release_stallF", StallF, 0);
        $display("txn load-use");

        // PC write pending / retiring.
        nxt(); PCWrPendingF = 1;
        mid(); chk("pcwr_stallF", StallF, 1); chk("pcwr_flushD", FlushD, 1);
        nxt(); PCWrPendingF = 0; PCSrcW = 1;
        mid(); chk("pcsrc_flushD", FlushD, 1); chk("pcsrc_stallF", StallF, 0);
        nxt(); clr();
        $display("txn pc write");

        // Multiply, MulOpE held for the 4 cycles.
        for (int c = 1; c <= 4; c++) begin
            nxt(); MulOpE = 1;
            mid();
            chk($sformatf("mul_c%0d_stall", c), {StallF, StallD, StallE, FlushM},
                (c < 4) ? 4'hF : 4'h0);
            chk($sformatf("mul_c%0d_busy", c), MulBusyE, (c > 1) ? 1 : 0);
            chk($sformatf("mul_c%0d_done", c), MulDoneE, (c == 4) ? 1 : 0);
            chk($sformatf("mul1_c%0d_stall", c), StallF_1, 0);
            $display("txn mul cycle %0d", c);
        end
        nxt(); clr();
        mid(); chk("mul_after_busy", MulBusyE, 0);

        // Branch taken during a multiply.
        nxt(); MulOpE = 1;
        for (int c = 2; c <= 4; c++) begin
            nxt(); MulOpE = 0; BranchTakenD = 1;
            mid();
            chk($sformatf("brmul_c%0d_flushD", c), FlushD, (c == 4) ? 1 : 0);
            chk($sformatf("brmul_c%0d_flushE", c), FlushE, (c == 4) ? 1 : 0);
            $display("txn branch during mul cycle %0d", c);
        end
        nxt(); clr();

        // Reset mid-multiply.
        nxt(); MulOpE = 1;
        nxt(); reset_n = 0;
        #1 chk_all_zero("rst_mid_mul_immediate");
        nxt(); MulOpE = 0; reset_n = 1;
        for (int c = 0; c < 4; c++) begin
            mid();
            chk("rst_mid_no_busy", MulBusyE, 0);
            chk("rst_mid_no_done", MulDoneE, 0);
            nxt();
        end
        $display("txn reset mid-multiply");

        // Performance counters: 3 stall cycles, then one branch flush.
        reset_n = 0;
        nxt(); reset_n = 1;
        nxt(); MulOpE = 1;
        nxt(); MulOpE = 0;
        nxt(); nxt();
        nxt(); BranchTakenD = 1;
        nxt(); clr();
        mid();
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_stall_cycles", StallCycles, 32'd3);
        chk("perf_flush_cycles", FlushCycles, 32'd4);
        $display("txn perf counters stall=%0d flush=%0d", StallCycles, FlushCycles);
`else
        chk("perf_seq_idle", MulBusyE, 0);
        $display("txn perf sequence (counters not built)");
`endif

        nxt(); nxt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
